// File: rtl/des_scan_byte_ctrl.sv
// rtl/des_scan_byte_ctrl.sv - SPI byte command front-end for the DES controller and its scan chain
module des_scan_byte_ctrl #(
    parameter int SHIFT_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       des_start,
    input  logic       des_busy,
    input  logic       des_done,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       err
);
    localparam logic [7:0] OP_START  = 8'h01;
    localparam logic [7:0] OP_STATUS = 8'h02;
    localparam logic [7:0] OP_CLRERR = 8'h03;
    localparam logic [7:0] OP_SCAN   = 8'h10;
    localparam logic [3:0] LAST_BIT  = 4'(SHIFT_BITS - 1);
    localparam logic [7:0] CAP_MASK  = 8'((9'd1 << SHIFT_BITS) - 9'd1);

    typedef enum logic [1:0] {S_CMD, S_ARG, S_SHIFT, S_FIN} state_t;

    state_t     r_state;
    logic [7:0] r_tx_byte;
    logic [7:0] r_sh_data;
    logic [7:0] r_cap;
    logic [3:0] r_bit_cnt;
    logic       r_des_start;
    logic       r_scan_enable;
    logic       r_scan_in;
    logic       r_err;
    logic       r_done_sticky;
    logic [3:0] w_next_cnt;

    assign w_next_cnt  = r_bit_cnt + 4'd1;
    assign tx_byte     = r_tx_byte;
    assign des_start   = r_des_start;
    assign scan_enable = r_scan_enable;
    assign scan_in     = r_scan_in;
    assign err         = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_CMD;
            r_tx_byte     <= 8'h00;
            r_sh_data     <= 8'h00;
            r_cap         <= 8'h00;
            r_bit_cnt     <= 4'd0;
            r_des_start   <= 1'b0;
            r_scan_enable <= 1'b0;
            r_scan_in     <= 1'b0;
            r_err         <= 1'b0;
            r_done_sticky <= 1'b0;
        end else begin
            r_des_start <= 1'b0;
            case (r_state)
                S_CMD: begin
                    if (rx_valid) begin
                        case (rx_byte)
                            OP_START: begin
                                if (des_busy) r_err <= 1'b1;
                                else          r_des_start <= 1'b1;
                            end
                            OP_STATUS: begin
                                r_tx_byte     <= {5'b0, r_err, r_done_sticky, des_busy};
                                r_done_sticky <= 1'b0;
                            end
                            OP_CLRERR: r_err   <= 1'b0;
                            OP_SCAN:   r_state <= S_ARG;
                            default:   r_err   <= 1'b1;
                        endcase
                    end
                end
                S_ARG: begin
                    if (rx_valid) begin
                        r_sh_data     <= rx_byte;
                        r_cap         <= 8'h00;
                        r_bit_cnt     <= 4'd0;
                        r_scan_enable <= 1'b1;
                        r_scan_in     <= rx_byte[0];
                        r_state       <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (rx_valid) r_err <= 1'b1;
                    // scan_out is the chain's bit k before this edge shifts sh_data[k] in
                    r_cap[r_bit_cnt[2:0]] <= scan_out;
                    if (r_bit_cnt == LAST_BIT) begin
                        r_scan_enable <= 1'b0;
                        r_scan_in     <= 1'b0;
                        r_state       <= S_FIN;
                    end else begin
                        r_bit_cnt <= w_next_cnt;
                        r_scan_in <= r_sh_data[w_next_cnt[2:0]];
                    end
                end
                S_FIN: begin
                    if (rx_valid) r_err <= 1'b1;
                    r_tx_byte <= r_cap & CAP_MASK;
                    r_bit_cnt <= 4'd0;
                    r_state   <= S_CMD;
                end
                default: r_state <= S_CMD;
            endcase
            // Placed last so a done pulse beats a same-cycle STATUS clear
            if (des_done) r_done_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_des_scan_byte_ctrl.sv
// tb/tb_des_scan_byte_ctrl.sv - randomized self-checking bench for des_scan_byte_ctrl
`timescale 1ns/1ps
module tb_des_scan_byte_ctrl;
    localparam int SB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic       des_start;
    logic       des_busy = 1'b0;
    logic       des_done = 1'b0;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;
    logic       err;

    int checks = 0;
    int failures = 0;

    logic       m_err = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_tx = 8'h00;

    logic [7:0] chain = 8'h00;
    logic       chain_load = 1'b0;
    logic [7:0] chain_load_val = 8'h00;

    des_scan_byte_ctrl #(.SHIFT_BITS(SB)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_byte(tx_byte), .des_start(des_start), .des_busy(des_busy),
        .des_done(des_done), .scan_enable(scan_enable), .scan_in(scan_in),
        .scan_out(scan_out), .err(err)
    );

    always #5 clk = ~clk;

    // 8-bit scan chain: shifts in at the MSB, presents its LSB on scan_out
    always @(posedge clk) begin
        if (chain_load)       chain <= chain_load_val;
        else if (scan_enable) chain <= {scan_in, chain[7:1]};
    end
    assign scan_out = chain[0];

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_byte = b;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic preload_chain(input logic [7:0] v);
        @(negedge clk); chain_load = 1'b1; chain_load_val = v;
        @(negedge clk); chain_load = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx: got %h want 00", tx_byte); end
        checks++; if ({des_start, scan_enable, scan_in, err} !== 4'b0000) begin failures++;
            $display("FAIL reset_outs: start/se/si/err got %b want 0000", {des_start, scan_enable, scan_in, err}); end
        rst_n = 1'b1;
        des_busy = 1'b0;
        send_byte(8'h02);
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_status: got %h want 00", tx_byte); end
        checks++; if (err !== 1'b0 || scan_enable !== 1'b0) begin failures++;
            $display("FAIL reset_status_flags: err=%b se=%b want 0 0", err, scan_enable); end
    endtask

    task automatic test_start;
        des_busy = 1'b0;
        send_byte(8'h01);
        checks++; if (des_start !== 1'b1) begin failures++; $display("FAIL start_pulse: got %b want 1", des_start); end
        @(negedge clk);
        checks++; if (des_start !== 1'b0) begin failures++; $display("FAIL start_width: got %b want 0", des_start); end
        des_done = 1'b1; @(negedge clk); des_done = 1'b0;
        send_byte(8'h02);
        checks++; if (tx_byte !== 8'h02) begin failures++; $display("FAIL start_done_status: got %h want 02", tx_byte); end
        send_byte(8'h02);
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL start_done_cleared: got %h want 00", tx_byte); end
    endtask

    task automatic test_start_busy;
        des_busy = 1'b1;
        send_byte(8'h01);
        checks++; if (des_start !== 1'b0 || err !== 1'b1) begin failures++;
            $display("FAIL start_busy: des_start=%b err=%b want 0 1", des_start, err); end
        des_busy = 1'b0;
        send_byte(8'h02);
        checks++; if (tx_byte !== 8'h04) begin failures++; $display("FAIL busy_status: got %h want 04", tx_byte); end
        send_byte(8'h03);
        send_byte(8'h02);
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL clrerr_status: got %h want 00", tx_byte); end
        m_err = 1'b0; m_done = 1'b0; m_tx = 8'h00;
    endtask

    task automatic test_done_vs_clear;
        @(negedge clk); rx_valid = 1'b1; rx_byte = 8'h02; des_done = 1'b1;
        @(negedge clk); rx_valid = 1'b0; des_done = 1'b0;
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL done_race_read: got %h want 00", tx_byte); end
        send_byte(8'h02);
        checks++; if (tx_byte !== 8'h02) begin failures++; $display("FAIL done_race_setwins: got %h want 02", tx_byte); end
        m_tx = 8'h02; m_done = 1'b0;
    endtask

    task automatic test_random_cmds;
        for (int i = 0; i < 16; i++) begin
            int sel;
            logic [7:0] op;
            sel = $urandom_range(0, 4);
            des_busy = 1'($urandom_range(0, 1));
            case (sel)
                0: begin
                    send_byte(8'h01);
                    checks++; if (des_start !== !des_busy) begin failures++;
                        $display("FAIL rand_start[%0d]: des_start=%b want %b", i, des_start, !des_busy); end
                    if (des_busy) m_err = 1'b1;
                end
                1: begin
                    m_tx = {5'b0, m_err, m_done, des_busy};
                    m_done = 1'b0;
                    send_byte(8'h02);
                end
                2: begin
                    send_byte(8'h03);
                    m_err = 1'b0;
                end
                3: begin
                    do op = 8'($urandom); while (op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h10);
                    send_byte(op);
                    m_err = 1'b1;
                end
                default: begin
                    @(negedge clk); des_done = 1'b1;
                    @(negedge clk); des_done = 1'b0;
                    m_done = 1'b1;
                end
            endcase
            checks++; if (tx_byte !== m_tx || err !== m_err) begin failures++;
                $display("FAIL rand_cmd[%0d] sel=%0d: tx=%h err=%b want tx=%h err=%b", i, sel, tx_byte, err, m_tx, m_err); end
        end
        des_busy = 1'b0;
        send_byte(8'h03);
        m_err = 1'b0;
    endtask

    task automatic do_scan(input logic [7:0] pre, input logic [7:0] data, input bit inject, input int tag);
        logic [7:0] prev_tx;
        prev_tx = m_tx;
        preload_chain(pre);
        send_byte(8'h10);
        @(negedge clk); rx_valid = 1'b1; rx_byte = data;
        for (int k = 0; k < SB; k++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            checks++; if (scan_enable !== 1'b1 || scan_in !== data[k] || des_start !== 1'b0) begin failures++;
                $display("FAIL scan%0d_bit%0d: se=%b si=%b start=%b want 1 %b 0", tag, k, scan_enable, scan_in, des_start, data[k]); end
            if (inject && k == 3) begin rx_valid = 1'b1; rx_byte = 8'h02; end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        checks++; if (scan_enable !== 1'b0 || tx_byte !== prev_tx) begin failures++;
            $display("FAIL scan%0d_fin: se=%b tx=%h want 0 %h", tag, scan_enable, tx_byte, prev_tx); end
        @(negedge clk);
        m_tx = pre;
        if (inject) m_err = 1'b1;
        checks++; if (tx_byte !== m_tx || chain !== data || err !== m_err) begin failures++;
            $display("FAIL scan%0d_result: tx=%h chain=%h err=%b want %h %h %b", tag, tx_byte, chain, err, m_tx, data, m_err); end
    endtask

    task automatic test_scan;
        do_scan(8'h3C, 8'hA5, 1'b0, 0);
        for (int i = 1; i < 6; i++) do_scan(8'($urandom), 8'($urandom), 1'b0, i);
    endtask

    task automatic test_overrun;
        do_scan(8'($urandom), 8'h5A, 1'b1, 100);
        send_byte(8'h03);
        m_err = 1'b0;
    endtask

    task automatic test_reset_mid_shift;
        preload_chain(8'($urandom));
        send_byte(8'h10);
        @(negedge clk); rx_valid = 1'b1; rx_byte = 8'($urandom);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        checks++; if (scan_enable !== 1'b1) begin failures++; $display("FAIL midreset_pre: se=%b want 1", scan_enable); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (scan_enable !== 1'b0) begin failures++; $display("FAIL midreset_async: se=%b want 0", scan_enable); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_err = 1'b0; m_done = 1'b0; m_tx = 8'h00;
        checks++; if (tx_byte !== 8'h00 || err !== 1'b0) begin failures++;
            $display("FAIL midreset_outs: tx=%h err=%b want 00 0", tx_byte, err); end
        send_byte(8'h02);
        checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL midreset_status: got %h want 00", tx_byte); end
        send_byte(8'h01);
        checks++; if (des_start !== 1'b1) begin failures++; $display("FAIL midreset_cmd_state: des_start=%b want 1", des_start); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_start_busy();
        test_done_vs_clear();
        test_random_cmds();
        test_scan();
        test_overrun();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/des_scan_byte_ctrl.md
# des_scan_byte_ctrl

Command front-end that sits directly upstream of the fixed-key DES round controller and its scan chain. It takes bytes delivered by the SPI slave receiver, decodes single-byte commands, and does three things: pulses the controller's `start`, reports busy/done/error status, and shifts whole bytes through the controller's 8-bit scan chain (round counter, state, busy history) while capturing the bits shifted out. It is the only driver of `scan_enable`/`scan_in` and of `start` for the DES controller.

## Interface
Parameters:
- `SHIFT_BITS`, 8: scan bits shifted per SCAN command; must be 1..8 and match the chain length.

Ports:
- `clk`  in  1  system clock; all flops rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle pulse; `rx_byte` is valid this cycle.
- `rx_byte`  in  8  byte received from SPI slave.
- `tx_byte`  out  8  registered byte returned on the next SPI transfer.
- `des_start`  out  1  one-cycle start pulse to the DES controller.
- `des_busy`  in  1  controller busy.
- `des_done`  in  1  controller done pulse.
- `scan_enable`  out  1  scan mode enable to the chain.
- `scan_in`  out  1  serial data into the chain.
- `scan_out`  in  1  serial data out of the chain (registered in the chain).
- `err`  out  1  sticky error flag.

## Operation
- Reset values: `tx_byte`=0x00, `des_start`=0, `scan_enable`=0, `scan_in`=0, `err`=0, `done_sticky`=0, state S_CMD, `bit_cnt`=0.
- States:
  - S_CMD: wait for `rx_valid`, then decode.
  - S_ARG: wait for the scan data byte.
  - S_SHIFT: shift SHIFT_BITS cycles.
  - S_FIN: one cycle to publish the result, then go to S_CMD.
- Opcodes, decoded in S_CMD:
  - 0x01 START: if `des_busy`=0, pulse `des_start`. Otherwise set `err` and issue no pulse.
  - 0x02 STATUS: `tx_byte` <= {5'b0, err, done_sticky, des_busy}, then clear `done_sticky`.
  - 0x03 CLRERR: `err` <= 0.
  - 0x10 SCAN: go to S_ARG. The next `rx_valid` byte is the shift data; load it into `sh_data` and go to S_SHIFT.
  - Any other opcode: set `err`. State and `tx_byte` are unchanged.
- S_SHIFT, for each cycle k = 0..SHIFT_BITS-1:
  - `scan_enable`=1 and `scan_in`=`sh_data[k]` (LSB first).
  - At the same clock edge, capture `scan_out` into `cap[k]`.
  - After the last bit go to S_FIN with `scan_enable`=0.
- S_FIN: `tx_byte` <= `cap`, with bits at index SHIFT_BITS and above set to zero.
- `done_sticky`: set on a `des_done` pulse in any state. If a STATUS clear lands on the same cycle as `des_done`, set wins.
- An `rx_valid` in S_SHIFT or S_FIN is an overrun: the byte is dropped and `err` is set.
- `scan_enable` is low in every state except S_SHIFT. A reset mid-shift returns to S_CMD immediately, with `scan_enable` deasserted asynchronously. The chain is left partially shifted; software must rescan.

## Timing
- START: `des_start` is high exactly in the cycle after the `rx_valid` carrying 0x01, and for 1 cycle only.
- STATUS: `tx_byte` is updated in the cycle after `rx_valid`. It holds until the next update.
- SCAN:
  - `scan_enable` rises in the cycle after the data-byte `rx_valid` and stays high for exactly SHIFT_BITS cycles.
  - `tx_byte` updates 1 cycle after `scan_enable` falls.
  - Total: SHIFT_BITS+2 cycles from the data byte to a valid `tx_byte`.
- `des_start` and `scan_enable` are never high in the same cycle.
- The SPI byte period is at least 16 `clk` cycles, so a correctly paced host never overruns with SHIFT_BITS=8.

## Test plan
- Reset, then send STATUS 0x02 with `des_busy`=0 -> `tx_byte`=0x00, `err`=0, `scan_enable`=0.
- Send START 0x01 with `des_busy`=0 -> one-cycle `des_start`. Then pulse `des_done`, send STATUS -> 0x02; send STATUS again -> 0x00.
- Send START with `des_busy`=1 -> no `des_start`, `err`=1. Then STATUS -> 0x04; CLRERR, then STATUS -> 0x00.
- Model the chain as an 8-bit shifter preloaded with 0x3C. Send 0x10, 0xA5 -> 8 cycles of `scan_enable`, `scan_in` sequence 1,0,1,0,0,1,0,1. Then `tx_byte`=0x3C and the chain holds 0xA5.
- Send 0x10, 0x5A, then inject `rx_valid` with 0x02 at shift cycle 3 -> byte dropped, `err`=1, shift completes normally, `tx_byte`=captured chain value.
- Deassert `rst_n` at shift cycle 4 -> `scan_enable`=0 asynchronously. After release, the state is S_CMD and a STATUS read returns 0x00.
